frame_capture_unit: RTL and testbench

Downstream of sequence_detection_unit, on the same per-clock 8-bit data stream. When the detector's flag marks a completed AB CD EF 24 sync sequence, this block captures the frame that follows: a length byte, then payload, then an XOR checksum byte. Valid payload is buffered and presented on a valid/ready byte stream with a last marker. Bad frames are reported with one-cycle pulses.

---
 rtl/seq_frame_pkg.sv | 28 ++
 rtl/frame_buffer.sv | 40 ++++
 rtl/frame_capture_unit.sv | 202 ++++++++++++++++++++
 tb/tb_frame_capture_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_frame_pkg.sv
// Shared definitions for the sync-framed capture path: FSM state codes,
// default payload depth, checksum width and the registered pulse bundle.
package seq_frame_pkg;

  localparam int MAX_LEN_DEFAULT = 16;
  localparam int CHK_W           = 8;

  // FSM state codes, binary encoded in two bits
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t PAYLOAD = 2'd1;
  localparam state_t CHECK   = 2'd2;
  localparam state_t SEND    = 2'd3;

  // Per-frame decision pulses; at most one is set for any decision
  typedef struct packed {
    logic ok;
    logic err;
    logic len_err;
    logic drop;
  } pulse_t;

  // Buffer address width: clog2 of the depth, never below one bit
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// Payload store: DEPTH x 8 register array with one synchronous write port
// and one combinational read port. Storage is not reset.
module frame_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);
      // Each entry captures the write byte when addressed
      always_ff @(posedge clk) begin
        if (we && (waddr == IDX)) begin
          mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Read is combinational; addresses beyond the depth return zero
  always_comb begin
    rdata = 8'h00;
    if ({1'b0, raddr} < DEPTH_C) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/frame_capture_unit.sv
// Frame capture behind the sync detector: on flag, takes a length byte,
// buffers the payload, checks an XOR checksum and streams the payload out
// on a valid/ready interface with a last marker. Decision pulses are
// registered. Optional macro FRAME_STATS_EN adds saturating 16-bit
// ok/err/drop counters as extra outputs.
module frame_capture_unit
  import seq_frame_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] data,
  input  logic       flag,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       len_err,
  output logic       frame_drop
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int PTR_W = ptr_width(MAX_LEN);
  localparam int CW    = PTR_W + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  pulse_t            pulse_q, pulse_d;

  logic              buf_we;
  logic [7:0]        buf_rdata;
  logic [CW-1:0]     len_m1;
  logic              in_send;
  logic              last_byte;

  assign len_m1    = len_q - 1'b1;
  assign in_send   = (state_q == SEND);
  assign last_byte = in_send && (rd_ptr_q == len_m1);

  frame_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q[PTR_W-1:0]),
    .wdata (data),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (buf_rdata)
  );

  // Stream outputs are gated by SEND so they read zero in reset and idle
  always_comb begin
    out_valid = in_send;
    out_data  = in_send ? buf_rdata : 8'h00;
    out_last  = last_byte;
  end

  assign frame_ok   = pulse_q.ok;
  assign frame_err  = pulse_q.err;
  assign len_err    = pulse_q.len_err;
  assign frame_drop = pulse_q.drop;

  // Next-state and datapath decisions for the capture FSM
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    chk_d    = chk_q;
    pulse_d  = '0;
    buf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flag) begin
          if (data == 8'h00) begin
            // Empty frame: only the checksum byte follows, which must be 0
            len_d   = '0;
            chk_d   = '0;
            state_d = CHECK;
          end else if (data > MAX_LEN_B) begin
            pulse_d.len_err = 1'b1;
          end else begin
            len_d   = CW'(data);
            chk_d   = data;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // flag is ignored here: the payload may legally contain the sync
        buf_we = 1'b1;
        chk_d  = chk_q ^ data;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == len_m1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (data == chk_q) begin
          pulse_d.ok = 1'b1;
          if (len_q == '0) begin
            state_d = IDLE;
          end else begin
            rd_ptr_d = '0;
            state_d  = SEND;
          end
        end else begin
          pulse_d.err = 1'b1;
          state_d     = IDLE;
        end
      end
      SEND: begin
        // A frame starting while we still drain is dropped whole
        if (flag) begin
          pulse_d.drop = 1'b1;
        end
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (last_byte) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture state registers; reset discards any frame in progress
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      chk_q    <= '0;
      pulse_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      chk_q    <= chk_d;
      pulse_q  <= pulse_d;
    end
  end

`ifdef FRAME_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating event counters driven by the registered pulses
  always_comb begin
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pulse_q.ok && (ok_cnt_q != 16'hFFFF)) begin
      ok_cnt_d = ok_cnt_q + 16'd1;
    end
    if ((pulse_q.err || pulse_q.len_err) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if (pulse_q.drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ok_cnt   = ok_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_capture_unit.sv
// Scoreboard bench for frame_capture_unit: stimulus pushes expected stream
// bytes and decision pulses into queues; a negedge monitor pops and compares.
module tb_frame_capture_unit;

  localparam int K_OK   = 1;
  localparam int K_ERR  = 2;
  localparam int K_LEN  = 3;
  localparam int K_DROP = 4;

  logic       clk;
  logic       nrst;
  logic [7:0] data;
  logic       flag;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       len_err;
  logic       frame_drop;

  int n_checks = 0;
  int n_pass   = 0;
  int rst_evt  = 0;

  int       pulse_q[$];
  logic [8:0] byte_q[$];   // {last, data}

  frame_capture_unit #(.MAX_LEN(16)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .data       (data),
    .flag       (flag),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .len_err    (len_err),
    .frame_drop (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge nrst) rst_evt++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic put(input logic [7:0] d, input logic f);
    data = d;
    flag = f;
    @(posedge clk);
    #1;
  endtask

  task automatic sync_seq();
    put(8'hAB, 1'b0);
    put(8'hCD, 1'b0);
    put(8'hEF, 1'b0);
    put(8'h24, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(8'h00, 1'b0);
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic last);
    byte_q.push_back({last, d});
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"},  int'(out_data), 0);
    chk({tag, "_last"},  int'(out_last), 0);
    chk({tag, "_pulses"}, int'({frame_ok, frame_err, len_err, frame_drop}), 0);
  endtask

  // Monitor: compare pulses and handshaked bytes against the queues
  logic       hold_pend = 1'b0;
  logic [8:0] hold_val  = '0;
  int         seen_rst  = 0;
  always @(negedge clk) begin
    if (nrst) begin
      if (seen_rst != rst_evt) begin
        hold_pend = 1'b0;
        seen_rst  = rst_evt;
      end
      if (hold_pend) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_word", int'({out_last, out_data}), int'(hold_val));
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_data};
      if (frame_ok || frame_err || len_err || frame_drop) begin
        int nh;
        nh = int'(frame_ok) + int'(frame_err) + int'(len_err) + int'(frame_drop);
        chk("pulse_excl", nh, 1);
        for (int k = K_OK; k <= K_DROP; k++) begin
          logic hi;
          hi = (k == K_OK) ? frame_ok : (k == K_ERR) ? frame_err :
               (k == K_LEN) ? len_err : frame_drop;
          if (hi) begin
            if (pulse_q.size() == 0) chk("pulse_unexpected", k, 0);
            else chk("pulse_kind", k, pulse_q.pop_front());
          end
        end
      end
      if (out_valid && out_ready) begin
        if (byte_q.size() == 0) chk("byte_unexpected", int'({out_last, out_data}), 0);
        else chk("byte_last_data", int'({out_last, out_data}), int'(byte_q.pop_front()));
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; data = 8'h00; flag = 1'b0; out_ready = 1'b1;
    #22;
    outputs_zero("reset");
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Good frame
    sync_seq();
    pulse_q.push_back(K_OK);
    exp_byte(8'h11, 0); exp_byte(8'h22, 0); exp_byte(8'h33, 1);
    put(8'h03, 1); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h03, 0);
    idle(4);

    // Checksum mismatch
    sync_seq();
    pulse_q.push_back(K_ERR);
    put(8'h03, 1); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h04, 0);
    idle(4);

    // Length error (0x20 and boundary 0x11), following bytes ignored
    sync_seq();
    pulse_q.push_back(K_LEN);
    put(8'h20, 1); put(8'h03, 0); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h03, 0);
    pulse_q.push_back(K_LEN);
    put(8'h11, 1);
    idle(3);

    // Length exactly MAX_LEN, payload 01..10, checksum 00
    pulse_q.push_back(K_OK);
    put(8'h10, 1);
    for (int i = 1; i <= 16; i++) begin
      exp_byte(8'(i), (i == 16));
      put(8'(i), 0);
    end
    put(8'h00, 0);
    idle(18);

    // Backpressure on byte 22, then a sync completing during SEND
    sync_seq();
    pulse_q.push_back(K_OK);
    pulse_q.push_back(K_DROP);
    exp_byte(8'h11, 0); exp_byte(8'h22, 0); exp_byte(8'h33, 1);
    put(8'h03, 1); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h03, 0);
    put(8'h00, 0);
    out_ready = 1'b0;
    put(8'hAB, 0); put(8'hCD, 0); put(8'hEF, 0);
    out_ready = 1'b1;
    put(8'h24, 0);
    put(8'h03, 1);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h03, 0);
    idle(3);

    // Zero length: good then bad checksum
    sync_seq();
    pulse_q.push_back(K_OK);
    put(8'h00, 1); put(8'h00, 0);
    idle(2);
    sync_seq();
    pulse_q.push_back(K_ERR);
    put(8'h00, 1); put(8'h01, 0);
    idle(3);

    // Back-to-back: flag in the IDLE cycle right after the last handshake
    pulse_q.push_back(K_OK);
    exp_byte(8'h5A, 1);
    put(8'h01, 1); put(8'h5A, 0); put(8'h5B, 0);
    put(8'h00, 0);
    pulse_q.push_back(K_OK);
    exp_byte(8'h77, 1);
    put(8'h01, 1); put(8'h77, 0); put(8'h76, 0);
    idle(3);

    // Reset during PAYLOAD
    sync_seq();
    put(8'h03, 1); put(8'h11, 0);
    #2 nrst = 1'b0;
    #1 outputs_zero("rst_payload");
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    pulse_q.push_back(K_OK);
    exp_byte(8'h5A, 1);
    sync_seq();
    put(8'h01, 1); put(8'h5A, 0); put(8'h5B, 0);
    idle(3);

    // Reset while SEND is stalled: valid must drop at once
    out_ready = 1'b0;
    pulse_q.push_back(K_OK);
    put(8'h02, 1); put(8'hAA, 0); put(8'hBB, 0); put(8'h13, 0);
    @(negedge clk); #1;
    chk("send_stalled_valid", int'(out_valid), 1);
    nrst = 1'b0;
    #1 outputs_zero("rst_send");
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    pulse_q.push_back(K_OK);
    exp_byte(8'h5A, 1);
    put(8'h01, 1); put(8'h5A, 0); put(8'h5B, 0);
    idle(4);

    chk("pulse_queue_empty", pulse_q.size(), 0);
    chk("byte_queue_empty", byte_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
